// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory port.
//   size_e  : request size encoding (byte / half / word / reserved)
//   WE_*    : mem_we encodings driven to the data memory
//   state_e : lsu_mem_port control FSM states
//   needs_rmw : a store whose lanes are not the low lanes of the word
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_WORD = 2'b01;
  localparam logic [1:0] WE_HALF = 2'b10;
  localparam logic [1:0] WE_BYTE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Memory only offers full-word, low-half and low-byte writes, so any
  // sub-word store that lands above lane 0 must read, merge and rewrite.
  function automatic logic needs_rmw(input logic store, input size_e size,
                                     input logic [1:0] off);
    return store && (((size == SIZE_BYTE) && (off != 2'b00)) ||
                     ((size == SIZE_HALF) && (off == 2'b10)));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for lsu_mem_port.
//   size, is_unsigned, offset : registered request attributes
//   rd_word   : word read from memory
//   wdata     : right-justified store data
//   load_data : rd_word shifted down by the byte offset and extended
//   merged_word : rd_word with the addressed lanes replaced by wdata
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  size_e                 size,
  input  logic                  is_unsigned,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged_word
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] lane_data;

  assign shamt   = {offset, 3'b000};
  assign shifted = rd_word >> shamt;

  always_comb begin
    load_data = shifted;
    lane_mask = '1;
    lane_data = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data = {{(DATA_WIDTH-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
        lane_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << shamt;
        lane_data = {{(DATA_WIDTH-8){1'b0}}, wdata[7:0]} << shamt;
      end
      SIZE_HALF: begin
        load_data = {{(DATA_WIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
        lane_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << shamt;
        lane_data = {{(DATA_WIDTH-16){1'b0}}, wdata[15:0]} << shamt;
      end
      default: ;
    endcase
    merged_word = (rd_word & ~lane_mask) | lane_data;
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit port to a single-ported, combinational-read data memory.
// Build option: define LSU_RMW_EN to support byte/half stores above lane 0
// by read-modify-write; without it those stores complete with resp_err.
//   req_*  : core request (valid/ready handshake, accepted only in IDLE)
//   resp_* : one-cycle completion pulse with extended load data / error
//   mem_*  : word-addressed memory port (mem_rd combinational from mem_a)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a request
// ST_ACCESS | memory addressed: load captured, direct store written,
//           | or RMW read word captured
// ST_WRITE  | merged word written back (RMW only)
// ST_RESP   | resp_valid pulse
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [1:0]               mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  state_e                   state, state_nxt;
  logic                     r_store;
  logic                     r_unsigned;
  size_e                    r_size;
  logic [ADDRESS_WIDTH+1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_merged;

  logic [1:0]               off;
  logic                     accept;
  logic                     rmw;
  logic                     rmw_err;
  logic                     err;
  logic [1:0]               direct_we;
  logic [DATA_WIDTH-1:0]    load_data;
  logic [DATA_WIDTH-1:0]    merged_word;

  assign off        = r_addr[1:0];
  assign req_ready  = (state == ST_IDLE);
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state == ST_RESP);
  assign rmw        = needs_rmw(r_store, r_size, off);

`ifdef LSU_RMW_EN
  assign rmw_err = 1'b0;
`else
  assign rmw_err = rmw;
`endif

  assign err = (r_size == SIZE_RSVD) ||
               ((r_size == SIZE_HALF) && off[0]) ||
               ((r_size == SIZE_WORD) && (off != 2'b00)) ||
               rmw_err;

  always_comb begin
    case (r_size)
      SIZE_BYTE: direct_we = WE_BYTE;
      SIZE_HALF: direct_we = WE_HALF;
      default:   direct_we = WE_WORD;
    endcase
  end

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .offset      (off),
    .rd_word     (mem_rd),
    .wdata       (r_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = WE_NONE;
    mem_a     = '0;
    mem_wd    = '0;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        mem_a     = r_addr[ADDRESS_WIDTH+1:2];
        state_nxt = ST_RESP;
        // err already covers RMW stores when the feature is compiled out
        if (!err && r_store) begin
          if (rmw) begin
            state_nxt = ST_WRITE;
          end else begin
            mem_we = direct_we;
            mem_wd = r_wdata;
          end
        end
      end
      ST_WRITE: begin
        mem_a     = r_addr[ADDRESS_WIDTH+1:2];
        mem_we    = WE_WORD;
        mem_wd    = r_merged;
        state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merged   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        r_store    <= req_store;
        r_unsigned <= req_unsigned;
        r_size     <= size_e'(req_size);
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end
      if (state == ST_ACCESS) begin
        r_merged   <= merged_word;
        resp_err   <= err;
        resp_rdata <= (!err && !r_store) ? load_data : '0;
      end
    end
  end

endmodule
